// File: rtl/elbeth_host_pkg.sv
// Shared definitions for the elbeth host monitor: state encoding, the
// to_host pass code and the widths of the status counters.
package elbeth_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam logic [31:0] HOST_PASS_CODE = 32'd1;

    localparam int HOST_W      = 32;
    localparam int FAIL_CODE_W = 31;
    localparam int CYCLE_W     = 32;
    localparam int FETCH_W     = 32;
    localparam int PRINT_W     = 16;
    localparam int STALL_W     = 16;

    // Terminal states are held until reset.
    function automatic logic is_terminal(input state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/elbeth_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module elbeth_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/elbeth_host_monitor.sv
// End-of-test monitor: decodes the to_host termination convention into
// sticky pass/fail/timeout status and counts run cycles and fetches.
// Optional watchdog (stall and run-length limits) is built only when
// ELBETH_HOST_MONITOR_WATCHDOG_EN is defined; otherwise timeout is 0.
module elbeth_host_monitor
    import elbeth_host_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter logic [15:0] STALL_CYCLES   = 16'd1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [HOST_W-1:0]      to_host,
    input  logic                   imem_en,
    input  logic                   imem_ready,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [FAIL_CODE_W-1:0] fail_code,
    output logic [PRINT_W-1:0]     print_count,
    output logic [CYCLE_W-1:0]     cycle_count,
    output logic [FETCH_W-1:0]     fetch_count
);

    state_t            state;
    state_t            next_state;
    logic [HOST_W-1:0] prev_to_host;
    logic              in_run;
    logic              fetch;
    logic              host_event;
    logic              pass_hit;
    logic              fail_hit;
    logic              print_hit;
    logic              timeout_hit;

    // Event qualification: a new nonzero to_host value seen while running.
    always_comb begin
        in_run     = (state == ST_RUN);
        fetch      = imem_en && imem_ready;
        host_event = in_run && (to_host != prev_to_host) && (to_host != '0);
        pass_hit   = host_event && (to_host == HOST_PASS_CODE);
        fail_hit   = host_event && to_host[0] && (to_host != HOST_PASS_CODE);
        print_hit  = host_event && !to_host[0];
    end

`ifdef ELBETH_HOST_MONITOR_WATCHDOG_EN
    logic [STALL_W-1:0] stall_cnt;

    elbeth_sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (fetch),
        .inc   (in_run && !fetch),
        .count (stall_cnt)
    );

    // Watchdog trips on a long fetch stall or on the run-length limit.
    always_comb begin
        timeout_hit = in_run &&
                      ((!fetch && (stall_cnt == STALL_CYCLES - 16'd1)) ||
                       (cycle_count == TIMEOUT_CYCLES - 32'd1));
    end
`else
    // Without the watchdog the monitor waits forever for a termination event.
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // Next-state decode; termination events take priority over the watchdog.
    always_comb begin
        // NOTE: next_state gets its default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            ST_IDLE: next_state = ST_RUN;
            ST_RUN: begin
                if (pass_hit) begin
                    next_state = ST_PASS;
                end else if (fail_hit) begin
                    next_state = ST_FAIL;
                end else if (timeout_hit) begin
                    next_state = ST_TIMEOUT;
                end
            end
            default: next_state = state;
        endcase
    end

    // State register, registered status flags and to_host history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            prev_to_host <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            fail_code    <= '0;
        end else begin
            state   <= next_state;
            done    <= is_terminal(next_state);
            pass    <= (next_state == ST_PASS);
            fail    <= (next_state == ST_FAIL);
            timeout <= (next_state == ST_TIMEOUT);
            // History stays 0 through IDLE so a value held across reset
            // release is still seen as an event in the first RUN cycle.
            if (state != ST_IDLE) begin
                prev_to_host <= to_host;
            end
            if (fail_hit) begin
                fail_code <= to_host[HOST_W-1:1];
            end
        end
    end

    elbeth_sat_counter #(.WIDTH(CYCLE_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (in_run),
        .count (cycle_count)
    );

    elbeth_sat_counter #(.WIDTH(FETCH_W)) u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (in_run && fetch),
        .count (fetch_count)
    );

    elbeth_sat_counter #(.WIDTH(PRINT_W)) u_print_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (print_hit),
        .count (print_count)
    );

endmodule

// File: tb/tb_elbeth_host_monitor.sv
// Self-checking bench for elbeth_host_monitor: directed scenarios plus
// randomized to_host / fetch traffic against a behavioural model.
`timescale 1ns/1ps
module tb_elbeth_host_monitor;

    localparam int STALL = 8;
    localparam int TMO   = 400;
`ifdef ELBETH_HOST_MONITOR_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] to_host = '0;
    logic        imem_en = 1'b0;
    logic        imem_ready = 1'b0;
    logic        done, pass, fail, timeout;
    logic [30:0] fail_code;
    logic [15:0] print_count;
    logic [31:0] cycle_count, fetch_count;

    always #5 clk = ~clk;

    elbeth_host_monitor #(
        .TIMEOUT_CYCLES (32'(TMO)),
        .STALL_CYCLES   (16'(STALL))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .to_host     (to_host),
        .imem_en     (imem_en),
        .imem_ready  (imem_ready),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .print_count (print_count),
        .cycle_count (cycle_count),
        .fetch_count (fetch_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: what the test has reported so far.
    bit          m_started, m_pass, m_fail, m_timeout;
    longint      m_cycle, m_fetch, m_print;
    int          m_stall_run;
    logic [31:0] m_prev, m_code;

    task automatic model_reset();
        m_started = 0; m_pass = 0; m_fail = 0; m_timeout = 0;
        m_cycle = 0; m_fetch = 0; m_print = 0; m_stall_run = 0;
        m_prev = '0; m_code = '0;
    endtask

    task automatic model_step(input logic [31:0] th, input bit fetched);
        bit ev;
        if (!m_started) begin
            m_started = 1;      // the single idle cycle after reset
            return;
        end
        if (m_pass || m_fail || m_timeout) return;
        ev = (th != m_prev) && (th != 0);
        m_prev = th;
        if (m_cycle < 64'hFFFF_FFFF) m_cycle++;
        if (fetched) begin
            if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
            m_stall_run = 0;
        end else begin
            m_stall_run++;
        end
        if (ev) begin
            if (th == 1) m_pass = 1;
            else if (th[0]) begin m_fail = 1; m_code = th >> 1; end
            else if (m_print < 65535) m_print++;
        end
        if (WD && !m_pass && !m_fail && (m_stall_run == STALL || m_cycle == TMO))
            m_timeout = 1;
    endtask

    task automatic compare_all(input string p);
        check({p, "_done"},    32'(done),      32'(m_pass | m_fail | m_timeout));
        check({p, "_pass"},    32'(pass),      32'(m_pass));
        check({p, "_fail"},    32'(fail),      32'(m_fail));
        check({p, "_timeout"}, 32'(timeout),   32'(m_timeout));
        check({p, "_code"},    32'(fail_code), m_code);
        check({p, "_print"},   32'(print_count), 32'(m_print));
        check({p, "_cycle"},   cycle_count,    32'(m_cycle));
        check({p, "_fetch"},   fetch_count,    32'(m_fetch));
    endtask

    // One clock: drive inputs, let the DUT sample, advance model, compare.
    task automatic tick(input string p, input logic [31:0] th, input bit en, input bit rdy);
        to_host = th; imem_en = en; imem_ready = rdy;
        @(posedge clk);
        model_step(th, en && rdy);
        @(negedge clk);
        compare_all(p);
    endtask

    // Asynchronous reset pulse placed away from any clock edge.
    task automatic do_reset(input string p);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all({p, "_async_rst"});
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all({p, "_in_rst"});
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_host();
        int r;
        logic [31:0] v;
        r = $urandom_range(0, 39);
        if (r == 0) return 32'd1;
        if (r == 1) begin
            v = $urandom | 32'd1;
            return (v == 32'd1) ? 32'd3 : v;
        end
        if (r < 10) return 32'd0;
        if (r < 25) begin
            case ($urandom_range(0, 3))
                0: return 32'h40;
                1: return 32'h42;
                2: return 32'd2;
                default: return 32'd4;
            endcase
        end
        return $urandom & ~32'd1;
    endfunction

    initial begin
        logic [31:0] th;
        int fetch_pct;

        // Reset state at time zero.
        model_reset();
        #2;
        compare_all("por");

        // Pass at cycle 10.
        do_reset("tp_pass");
        for (int i = 0; i < 10; i++) tick("tp_pass_run", 32'd0, 1'b1, 1'b1);
        tick("tp_pass_hit", 32'd1, 1'b1, 1'b1);
        check("tp_pass_flag", 32'(pass), 32'd1);
        check("tp_pass_done", 32'(done), 32'd1);
        check("tp_pass_cycles", cycle_count, 32'd10);
        for (int i = 0; i < 4; i++) tick("tp_pass_hold", 32'd0, 1'b1, 1'b1);
        check("tp_pass_frozen", cycle_count, 32'd10);

        // Fail with code 3; a later pass write changes nothing.
        do_reset("tp_fail");
        for (int i = 0; i < 3; i++) tick("tp_fail_run", 32'd0, 1'b1, 1'b1);
        tick("tp_fail_hit", 32'h7, 1'b1, 1'b1);
        check("tp_fail_flag", 32'(fail), 32'd1);
        check("tp_fail_code", 32'(fail_code), 32'd3);
        tick("tp_fail_then_pass", 32'd1, 1'b1, 1'b1);
        check("tp_fail_no_pass", 32'(pass), 32'd0);

        // Print sequence: 0 -> 0x40 -> 0x40 -> 0x42 -> 0 -> 0x40.
        do_reset("tp_print");
        tick("tp_print_idle", 32'd0, 1'b1, 1'b1);
        tick("tp_print_s0", 32'd0,   1'b1, 1'b1);
        tick("tp_print_s1", 32'h40,  1'b1, 1'b1);
        tick("tp_print_s2", 32'h40,  1'b1, 1'b1);
        tick("tp_print_s3", 32'h42,  1'b1, 1'b1);
        tick("tp_print_s4", 32'd0,   1'b1, 1'b1);
        tick("tp_print_s5", 32'h40,  1'b1, 1'b1);
        check("tp_print_count", 32'(print_count), 32'd3);
        check("tp_print_not_done", 32'(done), 32'd0);

        // 50 fetches, then a stall of STALL cycles.
        do_reset("tp_stall");
        tick("tp_stall_idle", 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) tick("tp_stall_fetch", 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < STALL; i++) tick("tp_stall_wait", 32'd0, 1'b1, 1'b0);
        check("tp_stall_timeout", 32'(timeout), 32'(WD));
        check("tp_stall_fetches", fetch_count, 32'd50);
        for (int i = 0; i < 4; i++) tick("tp_stall_after", 32'd0, 1'b1, 1'b0);

        // Pass arrives in the very cycle the stall limit hits.
        do_reset("tp_race");
        tick("tp_race_idle", 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick("tp_race_fetch", 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < STALL - 1; i++) tick("tp_race_wait", 32'd0, 1'b1, 1'b0);
        tick("tp_race_hit", 32'd1, 1'b1, 1'b0);
        check("tp_race_pass", 32'(pass), 32'd1);
        check("tp_race_timeout", 32'(timeout), 32'd0);

        // Run-length limit with fetches flowing.
        do_reset("tp_tmo");
        for (int i = 0; i < TMO + 5; i++) tick("tp_tmo_run", 32'd0, 1'b1, 1'b1);
        check("tp_tmo_timeout", 32'(timeout), 32'(WD));

        // Mid-run reset; nonzero to_host held across release is decoded.
        do_reset("tp_midrst");
        tick("tp_midrst_idle", 32'd0, 1'b1, 1'b1);
        tick("tp_midrst_p1", 32'd2, 1'b1, 1'b1);
        tick("tp_midrst_p2", 32'd4, 1'b0, 1'b1);
        tick("tp_midrst_p3", 32'd4, 1'b1, 1'b1);
        to_host = 32'h9;
        do_reset("tp_midrst_pulse");
        check("tp_midrst_cnt_clear", cycle_count, 32'd0);
        tick("tp_midrst_rel_idle", 32'h9, 1'b1, 1'b1);
        tick("tp_midrst_rel_run", 32'h9, 1'b1, 1'b1);
        check("tp_midrst_fail", 32'(fail), 32'd1);
        check("tp_midrst_code", 32'(fail_code), 32'd4);

        // Randomized runs.
        for (int run = 0; run < 20; run++) begin
            fetch_pct = (run % 2 == 0) ? 90 : 55;
            to_host = '0;
            do_reset("rnd");
            th = '0;
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 3) == 0) th = rand_host();
                tick("rnd", th, ($urandom_range(0, 99) < fetch_pct + 5),
                     ($urandom_range(0, 99) < fetch_pct + 5));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
